// File: rtl/simmem_wdata_matcher.sv
`default_nettype none
// ============================================================================
// Module   : simmem_wdata_matcher
// Purpose  : Reconciles AXI write addresses and data beats for the delay core.
// Revision : 1.0
// ============================================================================
module simmem_wdata_matcher #(
    parameter int IID_WIDTH        = 4,
    parameter int BURST_LEN_WIDTH  = 8,
    parameter int MAX_ORPHAN_BEATS = 64,
    parameter int QUEUE_DEPTH      = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  waddr_valid_i,
    output logic                                  waddr_ready_o,
    input  logic [IID_WIDTH-1:0]                  waddr_iid_i,
    input  logic [BURST_LEN_WIDTH-1:0]            waddr_burst_len_i,
    input  logic                                  wdata_valid_i,
    output logic                                  wdata_ready_o,
    input  logic                                  wdata_last_i,
    output logic                                  core_waddr_valid_o,
    input  logic                                  core_waddr_ready_i,
    output logic [IID_WIDTH-1:0]                  core_waddr_iid_o,
    output logic [BURST_LEN_WIDTH-1:0]            core_waddr_burst_len_o,
    output logic [BURST_LEN_WIDTH-1:0]            core_wdata_immediate_cnt_o,
    output logic                                  core_wdata_valid_o,
    output logic [IID_WIDTH-1:0]                  core_wdata_iid_o,
    output logic                                  burst_done_valid_o,
    output logic [IID_WIDTH-1:0]                  burst_done_iid_o,
    output logic [$clog2(MAX_ORPHAN_BEATS+1)-1:0] orphan_cnt_o,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]      queue_cnt_o,
    output logic                                  err_o
);

    localparam int c_ORPH_W = $clog2(MAX_ORPHAN_BEATS + 1);
    localparam int c_QCNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int c_PTR_W  = $clog2(QUEUE_DEPTH);
    localparam int c_CMP_W  = (c_ORPH_W + 1 > BURST_LEN_WIDTH) ? c_ORPH_W + 1 : BURST_LEN_WIDTH;

    logic [IID_WIDTH-1:0]       r_iid [QUEUE_DEPTH];
    logic [BURST_LEN_WIDTH-1:0] r_rem [QUEUE_DEPTH];
    logic [c_PTR_W-1:0]         r_rd_ptr;
    logic [c_PTR_W-1:0]         r_wr_ptr;
    logic [c_QCNT_W-1:0]        r_queue_cnt;
    logic [c_ORPH_W-1:0]        r_orphan_cnt;
    logic                       r_err;

    logic                       w_empty;
    logic                       w_not_full;
    logic                       w_beat_acc;
    logic                       w_addr_acc;
    logic                       w_len_zero;
    logic [c_CMP_W-1:0]         w_avail;
    logic [c_CMP_W-1:0]         w_len_ext;
    logic [BURST_LEN_WIDTH-1:0] w_imm;
    logic [BURST_LEN_WIDTH-1:0] w_head_rem;
    logic                       w_head_last;
    logic                       w_head_beat;
    logic                       w_pop;
    logic                       w_push;
    logic [BURST_LEN_WIDTH-1:0] w_push_rem;
    logic                       w_addr_done;
    logic [c_ORPH_W-1:0]        w_orphan_next;
    logic                       w_err_set;

    assign w_empty     = (r_queue_cnt == '0);
    assign w_not_full  = (r_queue_cnt < c_QCNT_W'(QUEUE_DEPTH));
    assign w_len_zero  = (waddr_burst_len_i == '0);

    assign wdata_ready_o      = !w_empty || (r_orphan_cnt < c_ORPH_W'(MAX_ORPHAN_BEATS));
    assign waddr_ready_o      = core_waddr_ready_i && w_not_full;
    assign core_waddr_valid_o = waddr_valid_i && w_not_full;
    assign w_beat_acc         = wdata_valid_i && wdata_ready_o;
    assign w_addr_acc         = waddr_valid_i && waddr_ready_o;

    // Orphans only exist with an empty FIFO, so only then can they satisfy a new address.
    assign w_avail   = c_CMP_W'(r_orphan_cnt) + c_CMP_W'(w_beat_acc);
    assign w_len_ext = c_CMP_W'(waddr_burst_len_i);
    assign w_imm     = !w_empty ? '0 :
                       (w_avail >= w_len_ext) ? waddr_burst_len_i : w_avail[BURST_LEN_WIDTH-1:0];

    assign w_head_rem  = r_rem[r_rd_ptr];
    assign w_head_last = (w_head_rem == BURST_LEN_WIDTH'(1));
    assign w_head_beat = !w_empty && w_beat_acc;
    assign w_pop       = w_head_beat && w_head_last;
    assign w_addr_done = w_empty && w_addr_acc && !w_len_zero && (w_imm == waddr_burst_len_i);
    assign w_push      = w_addr_acc && !w_len_zero && !w_addr_done;
    assign w_push_rem  = waddr_burst_len_i - w_imm;

    assign w_orphan_next = !w_empty ? r_orphan_cnt :
                           c_ORPH_W'(w_avail - (w_addr_acc ? c_CMP_W'(w_imm) : c_CMP_W'(0)));

    assign w_err_set = (w_addr_acc && w_len_zero) ||
                       (w_head_beat && (wdata_last_i != w_head_last));

    assign core_waddr_iid_o           = waddr_iid_i;
    assign core_waddr_burst_len_o     = waddr_burst_len_i;
    assign core_wdata_immediate_cnt_o = core_waddr_valid_o ? w_imm : '0;
    assign core_wdata_valid_o         = w_head_beat;
    assign core_wdata_iid_o           = r_iid[r_rd_ptr];
    assign burst_done_valid_o         = w_pop || w_addr_done;
    assign burst_done_iid_o           = w_empty ? waddr_iid_i : r_iid[r_rd_ptr];
    assign orphan_cnt_o               = r_orphan_cnt;
    assign queue_cnt_o                = r_queue_cnt;
    assign err_o                      = r_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_iid[i] <= '0;
                r_rem[i] <= '0;
            end
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_queue_cnt  <= '0;
            r_orphan_cnt <= '0;
            r_err        <= 1'b0;
        end else begin
            // Push and head decrement never share a slot: a push into an empty FIFO has no head beat.
            if (w_head_beat) begin
                r_rem[r_rd_ptr] <= w_head_rem - BURST_LEN_WIDTH'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push) begin
                r_iid[r_wr_ptr] <= waddr_iid_i;
                r_rem[r_wr_ptr] <= w_push_rem;
                r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_queue_cnt <= r_queue_cnt + c_QCNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_queue_cnt <= r_queue_cnt - c_QCNT_W'(1);
            end
            r_orphan_cnt <= w_orphan_next;
            r_err        <= r_err || w_err_set;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_simmem_wdata_matcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_simmem_wdata_matcher
// Purpose  : Directed and random checks of simmem_wdata_matcher against a queue model.
// Revision : 1.0
// ============================================================================
module tb_simmem_wdata_matcher;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       waddr_valid = 1'b0;
    logic       waddr_ready;
    logic [3:0] waddr_iid = '0;
    logic [7:0] waddr_len = '0;
    logic       wdata_valid = 1'b0;
    logic       wdata_ready;
    logic       wdata_last = 1'b0;
    logic       core_waddr_valid;
    logic       core_waddr_ready = 1'b1;
    logic [3:0] core_waddr_iid;
    logic [7:0] core_waddr_len;
    logic [7:0] core_imm;
    logic       core_wdata_valid;
    logic [3:0] core_wdata_iid;
    logic       done_valid;
    logic [3:0] done_iid;
    logic [6:0] orphan_cnt;
    logic [2:0] queue_cnt;
    logic       err;

    always #5 clk = ~clk;

    simmem_wdata_matcher dut (
        .clk_i                      (clk),
        .rst_i                      (rst),
        .waddr_valid_i              (waddr_valid),
        .waddr_ready_o              (waddr_ready),
        .waddr_iid_i                (waddr_iid),
        .waddr_burst_len_i          (waddr_len),
        .wdata_valid_i              (wdata_valid),
        .wdata_ready_o              (wdata_ready),
        .wdata_last_i               (wdata_last),
        .core_waddr_valid_o         (core_waddr_valid),
        .core_waddr_ready_i         (core_waddr_ready),
        .core_waddr_iid_o           (core_waddr_iid),
        .core_waddr_burst_len_o     (core_waddr_len),
        .core_wdata_immediate_cnt_o (core_imm),
        .core_wdata_valid_o         (core_wdata_valid),
        .core_wdata_iid_o           (core_wdata_iid),
        .burst_done_valid_o         (done_valid),
        .burst_done_iid_o           (done_iid),
        .orphan_cnt_o               (orphan_cnt),
        .queue_cnt_o                (queue_cnt),
        .err_o                      (err)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: pending bursts as queues, orphans as a plain count.
    int q_iid[$];
    int q_rem[$];
    int m_orphan = 0;
    bit m_err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit model_last();
        return (q_rem.size() != 0) && (q_rem[0] == 1);
    endfunction

    // Applies inputs for one cycle, checks all outputs mid-cycle, then advances the model.
    task automatic cyc(input bit av, input int iid, input int len, input bit wv,
                       input bit last, input bit cr);
        int n, avail, imm, diid;
        bit empty, full, wr, beat, ar, addr, dv;
        waddr_valid      = av;
        waddr_iid        = iid[3:0];
        waddr_len        = len[7:0];
        wdata_valid      = wv;
        wdata_last       = last;
        core_waddr_ready = cr;
        @(negedge clk);
        n     = q_iid.size();
        empty = (n == 0);
        full  = (n == 4);
        wr    = !empty || (m_orphan < 64);
        beat  = wv && wr;
        ar    = cr && !full;
        addr  = av && ar;
        avail = m_orphan + int'(beat);
        imm   = empty ? ((len < avail) ? len : avail) : 0;
        if (!empty) begin
            dv   = beat && (q_rem[0] == 1);
            diid = q_iid[0];
        end else begin
            dv   = addr && (len != 0) && (imm == len);
            diid = iid;
        end
        chk("orphan_cnt", 32'(orphan_cnt), m_orphan);
        chk("queue_cnt", 32'(queue_cnt), n);
        chk("err", 32'(err), 32'(m_err));
        chk("wdata_ready", 32'(wdata_ready), 32'(wr));
        chk("waddr_ready", 32'(waddr_ready), 32'(ar));
        chk("core_waddr_valid", 32'(core_waddr_valid), 32'(av && !full));
        if (av && !full) begin
            chk("imm_cnt", 32'(core_imm), imm);
            chk("core_waddr_iid", 32'(core_waddr_iid), iid);
            chk("core_waddr_len", 32'(core_waddr_len), len);
        end
        chk("core_wdata_valid", 32'(core_wdata_valid), 32'(beat && !empty));
        if (beat && !empty) chk("core_wdata_iid", 32'(core_wdata_iid), q_iid[0]);
        chk("done_valid", 32'(done_valid), 32'(dv));
        if (dv) chk("done_iid", 32'(done_iid), diid);
        @(posedge clk);
        if (!empty && beat) begin
            if (last != (q_rem[0] == 1)) m_err = 1'b1;
            q_rem[0] = q_rem[0] - 1;
            if (q_rem[0] == 0) begin
                void'(q_rem.pop_front());
                void'(q_iid.pop_front());
            end
        end
        if (addr) begin
            if (len == 0) m_err = 1'b1;
            else if (!empty) begin
                q_iid.push_back(iid);
                q_rem.push_back(len);
            end else if (imm < len) begin
                q_iid.push_back(iid);
                q_rem.push_back(len - imm);
            end
        end
        if (empty) m_orphan = avail - (addr ? imm : 0);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    endtask

    // Reset is asserted between edges so its asynchronous effect is visible at once.
    task automatic do_reset();
        waddr_valid      = 1'b0;
        wdata_valid      = 1'b0;
        wdata_last       = 1'b0;
        core_waddr_ready = 1'b1;
        rst = 1'b1;
        #1;
        q_iid.delete();
        q_rem.delete();
        m_orphan = 0;
        m_err    = 1'b0;
        chk("rst_queue_cnt", 32'(queue_cnt), 0);
        chk("rst_orphan_cnt", 32'(orphan_cnt), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_wdata_ready", 32'(wdata_ready), 1);
        chk("rst_waddr_ready", 32'(waddr_ready), 1);
        chk("rst_done_valid", 32'(done_valid), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // Address before data.
        cyc(1'b1, 3, 4, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 0, 0, 1'b1, (i == 3), 1'b1);
        chk("a2d_err", 32'(err), 0);
        chk("a2d_queue_empty", 32'(queue_cnt), 0);

        // Data before address, then same-cycle beat and address.
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1, 3, 1'b0, 1'b0, 1'b1);
        chk("d2a_orphan", 32'(orphan_cnt), 2);
        cyc(1'b1, 5, 3, 1'b1, 1'b0, 1'b1);
        chk("same_cycle_orphan", 32'(orphan_cnt), 0);
        chk("same_cycle_no_push", 32'(queue_cnt), 0);

        // Orphan saturation.
        do_reset();
        for (int i = 0; i < 66; i++) cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
        chk("sat_ready_low", 32'(wdata_ready), 0);
        cyc(1'b1, 2, 10, 1'b0, 1'b0, 1'b1);
        chk("sat_orphan", 32'(orphan_cnt), 54);
        chk("sat_ready_back", 32'(wdata_ready), 1);

        // Queue full, then drain the head so the fifth address gets in.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, i, 2, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 4, 2, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 4, 2, 1'b1, 1'b0, 1'b1);
        chk("full_after_one_beat", 32'(queue_cnt), 4);
        cyc(1'b1, 4, 2, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 4, 2, 1'b0, 1'b0, 1'b1);
        chk("fifth_accepted", 32'(queue_cnt), 4);
        cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);

        // Mid-burst reset with entries pending, then a WLAST error that must stick.
        do_reset();
        cyc(1'b1, 7, 2, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 0, 0, 1'b1, 1'b1, 1'b1);
        chk("wlast_err_set", 32'(err), 1);
        for (int i = 0; i < 4; i++) idle();
        chk("wlast_err_sticky", 32'(err), 1);
        do_reset();

        // Zero-length address sets the error and leaves orphans alone.
        cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 9, 0, 1'b0, 1'b0, 1'b1);
        chk("len0_err", 32'(err), 1);
        do_reset();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bit av, wv, last, cr;
            int len;
            if (i % 600 == 599) do_reset();
            av   = ($urandom_range(0, 1) == 1);
            len  = ($urandom_range(0, 40) == 0) ? 0 : $urandom_range(1, 6);
            wv   = ($urandom_range(0, 9) < 6);
            cr   = ($urandom_range(0, 3) != 0);
            last = model_last();
            if ($urandom_range(0, 59) == 0) last = !last;
            cyc(av, $urandom_range(0, 15), len, wv, last, cr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/simmem_wdata_matcher.md
# simmem_wdata_matcher

Parametrised write-data/write-address reconciler between the requester-side snoop and the delay calculator core. It accepts AXI write-address and write-data handshakes in any relative order and keeps a bounded count of orphan data beats, i.e. beats that arrive before their address. It also keeps a FIFO of addressed bursts still awaiting beats. The core receives each address once, with the count of beats already available, then one pulse per later beat. Unlike the always-ready predecessor, this block has bounded storage with backpressure, a multi-burst queue, per-beat IID tagging, burst-completion reporting and WLAST checking.

## Interface
- IidWidth, 4: width of internal write identifier.
- BurstLenWidth, 8: width of burst length field; burst length is a beat count, legal range 1..2^BurstLenWidth-1.
- MaxOrphanBeats, 64: orphan counter saturation limit; counter width $clog2(MaxOrphanBeats+1).
- QueueDepth, 4: entries in the pending-burst FIFO; power of two, >=2.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- waddr_valid_i  in  1  requester address valid.
- waddr_ready_o  out  1  address accepted.
- waddr_iid_i  in  IidWidth  IID of the address.
- waddr_burst_len_i  in  BurstLenWidth  beats in the burst.
- wdata_valid_i  in  1  requester data beat valid.
- wdata_ready_o  out  1  beat accepted.
- wdata_last_i  in  1  WLAST of the beat.
- core_waddr_valid_o  out  1  address handoff to core.
- core_waddr_ready_i  in  1  core has a write slot.
- core_waddr_iid_o  out  IidWidth  equals waddr_iid_i.
- core_waddr_burst_len_o  out  BurstLenWidth  equals waddr_burst_len_i.
- core_wdata_immediate_cnt_o  out  BurstLenWidth  beats already available at handoff.
- core_wdata_valid_o  out  1  one-cycle pulse per beat delivered after handoff.
- core_wdata_iid_o  out  IidWidth  IID owning that beat.
- burst_done_valid_o  out  1  pulse when a burst's last beat is accounted.
- burst_done_iid_o  out  IidWidth  IID of completed burst.
- orphan_cnt_o  out  $clog2(MaxOrphanBeats+1)  current orphan beats.
- queue_cnt_o  out  $clog2(QueueDepth+1)  occupied FIFO entries.
- err_o  out  1  sticky protocol error.

## Operation
- Invariant: orphan_cnt > 0 implies the FIFO is empty.
- Beat accept: wdata_valid_i && wdata_ready_o.
  - wdata_ready_o = (queue_cnt != 0) || (orphan_cnt < MaxOrphanBeats).
- Address accept: waddr_valid_i && waddr_ready_o.
  - waddr_ready_o = core_waddr_ready_i && (queue_cnt < QueueDepth).
  - core_waddr_valid_o = waddr_valid_i && (queue_cnt < QueueDepth).
  - Both are combinational from inputs and state.
- Beat with FIFO non-empty:
  - core_wdata_valid_o=1 and core_wdata_iid_o=head.iid.
  - head.remaining is decremented.
  - At 1->0: pop the head, burst_done_valid_o=1, burst_done_iid_o=head.iid.
  - WLAST check: wdata_last_i must equal (head.remaining==1); a mismatch sets err_o.
- Beat with FIFO empty: the beat becomes an orphan, core_wdata_valid_o=0, and WLAST is not checked.
- Address with FIFO empty:
  - avail = orphan_cnt + (beat accepted this cycle).
  - imm = min(avail, len).
  - orphan_cnt_next = avail - imm.
  - If imm==len: burst_done pulse with waddr_iid_i in the same cycle, no push.
  - Else: push {iid, remaining=len-imm}.
- Address with FIFO non-empty: imm=0; push {iid, len}. A same-cycle beat goes to the old head before the push.
- core_wdata_immediate_cnt_o = imm whenever core_waddr_valid_o is high.
- A same-cycle push and pop are both applied; queue_cnt is unchanged.
- burst_done has a single source per cycle: the address path when the FIFO is empty, the head pop otherwise.
- waddr_burst_len_i==0 on an address handshake sets err_o. Such an address is handed off with imm=0 and is not pushed.
- err_o is cleared only by reset.

## Timing
- While rst_i is high and after reset, FIFO is empty, counters are 0 and err_o=0.
  - All pulse outputs are 0.
  - wdata_ready_o=1.
  - waddr_ready_o follows core_waddr_ready_i.
- Asserting rst_i mid-burst discards all FIFO entries and orphans asynchronously.
- Core handoff has zero latency: same cycle as the requester handshake.
- core_wdata_valid_o and burst_done_valid_o are asserted in the acceptance cycle and last one cycle.
- State (FIFO, orphan_cnt, err_o) updates at the next rising edge; orphan_cnt_o and queue_cnt_o are registered.
- At orphan saturation (orphan_cnt==MaxOrphanBeats, FIFO empty), wdata_ready_o=0 until an address drains orphans.
- FIFO full: no new address is presented to the core; beats still drain the head.
- FIFO pointers wrap modulo QueueDepth.

## Test plan
- Address before data: addr len=4 iid=3, then 4 beats with last on the 4th -> handoff imm=0; four core_wdata pulses iid=3; burst_done iid=3 on 4th beat; err_o=0.
- Data before address: 5 beats, then addr len=3 iid=1 -> imm=3, burst_done iid=1 in the handshake cycle, orphan_cnt_o=2 next cycle.
- Same-cycle beat and address with orphan_cnt=2 and len=3 -> imm=3, orphan_cnt_o=0, no push.
- Saturation: 64 beats, no address -> wdata_ready_o=0. Then addr len=10 -> wdata_ready_o=1 next cycle, orphan_cnt_o=54.
- Queue full: 4 addresses len=2, no data -> 5th address sees waddr_ready_o=0 and core_waddr_valid_o=0. One beat -> still full. 2nd beat pops the head -> 5th accepted.
- WLAST error: addr len=2, beat 1 with last=1 -> err_o=1 next cycle and stays set until rst_i pulses.
